// File: rtl/aes_key_expander_if.sv
// Key-expander port bundle: start handshake, key input and round-key read port.
interface aes_key_expander_if;
    logic         init;
    logic [127:0] key;
    logic         ready;
    logic         key_exp_done;
    logic [3:0]   round_idx;
    logic [127:0] round_key;

    modport master (
        output init, key, round_idx,
        input  ready, key_exp_done, round_key
    );

    modport slave (
        input  init, key, round_idx,
        output ready, key_exp_done, round_key
    );
endinterface

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule; one shared S-box walks the SubWord bytes.
// Round keys land in a register bank served through a combinational read mux.
module aes_key_expander (
    input logic              clk,
    input logic              reset_n,
    aes_key_expander_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SUB, GEN, DONE} state_t;

    state_t       r_state;
    state_t       w_next;
    logic [3:0]   r_round;
    logic [1:0]   r_byte;
    logic [31:0]  r_temp;
    logic [127:0] r_rk [11];

    logic         w_load;
    logic         w_sub;
    logic         w_gen;
    logic [127:0] w_prev;
    logic [31:0]  w_rot;
    logic [7:0]   w_sb_in;
    logic [7:0]   w_sb_out;
    logic [31:0]  w_s;
    logic [31:0]  w_n0;
    logic [31:0]  w_n1;
    logic [31:0]  w_n2;
    logic [31:0]  w_n3;
    logic [127:0] w_rd;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254, then the FIPS-197 affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] y;
        logic [7:0] acc;
        y   = gf_mul(x, x);
        acc = y;
        for (int i = 0; i < 6; i++) begin
            y   = gf_mul(y, y);
            acc = gf_mul(acc, y);
        end
        return acc
            ^ {acc[6:0], acc[7]}
            ^ {acc[5:0], acc[7:6]}
            ^ {acc[4:0], acc[7:5]}
            ^ {acc[3:0], acc[7:4]}
            ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        v = 8'h00;
        unique case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_sub  = 1'b0;
        w_gen  = 1'b0;
        unique case (r_state)
            IDLE, DONE: begin
                if (bus.init) begin
                    w_load = 1'b1;
                    w_next = SUB;
                end
            end
            SUB: begin
                w_sub = 1'b1;
                if (r_byte == 2'd3) w_next = GEN;
            end
            GEN: begin
                w_gen  = 1'b1;
                w_next = (r_round == 4'd10) ? DONE : SUB;
            end
            default: w_next = IDLE;
        endcase
    end

    // Previous round key, selected by the 4-bit round counter.
    always_comb begin
        w_prev = '0;
        for (int i = 0; i < 11; i++)
            if (r_round == 4'(i + 1)) w_prev = r_rk[i];
    end

    assign w_rot    = {w_prev[23:0], w_prev[31:24]};
    assign w_sb_in  = w_rot[{~r_byte, 3'b000} +: 8];
    assign w_sb_out = sbox(w_sb_in);
    assign w_s      = r_temp ^ {rcon(r_round), 24'h0};
    assign w_n0     = w_prev[127:96] ^ w_s;
    assign w_n1     = w_prev[95:64] ^ w_n0;
    assign w_n2     = w_prev[63:32] ^ w_n1;
    assign w_n3     = w_prev[31:0] ^ w_n2;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_round <= 4'd0;
            r_byte  <= 2'd0;
            r_temp  <= 32'h0;
            for (int i = 0; i < 11; i++) r_rk[i] <= '0;
        end else begin
            if (w_load) begin
                r_rk[0] <= bus.key;
                r_round <= 4'd1;
                r_byte  <= 2'd0;
            end
            if (w_sub) begin
                r_temp[{~r_byte, 3'b000} +: 8] <= w_sb_out;
                r_byte <= r_byte + 2'd1;
            end
            if (w_gen) begin
                for (int i = 1; i < 11; i++)
                    if (r_round == 4'(i)) r_rk[i] <= {w_n0, w_n1, w_n2, w_n3};
                if (r_round != 4'd10) r_round <= r_round + 4'd1;
            end
        end
    end

    always_comb begin
        w_rd = '0;
        for (int i = 0; i < 11; i++)
            if (bus.round_idx == 4'(i)) w_rd = r_rk[i];
    end

    assign bus.round_key    = w_rd;
    assign bus.ready        = (r_state == IDLE) || (r_state == DONE);
    assign bus.key_exp_done = (r_state == DONE);
endmodule

// File: tb/tb_aes_key_expander.sv
// Scoreboard bench: FIPS-197 word-recurrence model versus the iterative expander.
module tb_aes_key_expander;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_key_expander_if bus ();

    aes_key_expander dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    localparam logic [2047:0] SBV = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef struct packed {
        logic [10:0][127:0] rk;
        logic [31:0]        e0;
    } exp_t;

    exp_t q[$];

    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBV[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [10:0][127:0] expand(input logic [127:0] k);
        logic [31:0]        w [44];
        logic [31:0]        t;
        logic [7:0]         rc;
        logic [10:0][127:0] o;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])};
                t = t ^ {rc, 24'h0};
                rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            o[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
        return o;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic start(input logic [127:0] k);
        exp_t it;
        int   n;
        n = 0;
        @(negedge clk);
        while (!bus.ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_init", 128'(bus.ready), 128'd1);
        bus.key  = k;
        bus.init = 1'b1;
        @(posedge clk);
        #1;
        it.rk = expand(k);
        it.e0 = cyc;
        q.push_back(it);
        @(negedge clk);
        bus.init = 1'b0;
        chk("ready_busy", 128'(bus.ready), 128'd0);
        chk("done_busy", 128'(bus.key_exp_done), 128'd0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!bus.key_exp_done && n < 120) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 128'(bus.key_exp_done), 128'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic kat(input int idx, input logic [127:0] exp);
        bus.round_idx = 4'(idx);
        #1;
        chk($sformatf("kat_rk%0d", idx), bus.round_key, exp);
    endtask

    task automatic check_cleared();
        chk("rst_ready", 128'(bus.ready), 128'd1);
        chk("rst_done", 128'(bus.key_exp_done), 128'd0);
        for (int i = 0; i < 16; i++) begin
            bus.round_idx = 4'(i);
            #1;
            chk($sformatf("rst_rk%0d", i), bus.round_key, 128'h0);
        end
    endtask

    // Monitor: on each rising key_exp_done, pop and compare the whole bank.
    initial begin
        logic prev;
        exp_t it;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.key_exp_done && !prev) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 128'd1, 128'd0);
                end else begin
                    it = q.pop_front();
                    chk("latency", 128'(cyc - int'(it.e0)), 128'd50);
                    for (int i = 0; i < 16; i++) begin
                        bus.round_idx = 4'(i);
                        #1;
                        chk($sformatf("rk%0d", i), bus.round_key,
                            (i <= 10) ? it.rk[i] : 128'h0);
                    end
                end
            end
            prev = bus.key_exp_done;
        end
    end

    initial begin
        logic [127:0] ka;
        logic [127:0] kb;
        exp_t         it;
        bus.init      = 1'b0;
        bus.key       = '0;
        bus.round_idx = '0;
        reset_n       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check_cleared();

        start(128'h2b7e151628aed2a6abf7158809cf4f3c);
        wait_done();
        kat(1, 128'ha0fafe1788542cb123a339392a6c7605);
        kat(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        start(128'h000102030405060708090a0b0c0d0e0f);
        wait_done();
        kat(10, 128'h13111d7fe3944a17f307a78b4d2b30c5);

        start(128'h0);
        wait_done();
        kat(1, 128'h62636363626363636263636362636363);
        kat(10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        start(ka);
        repeat (19) @(negedge clk);
        bus.key  = kb;
        bus.init = 1'b1;
        @(negedge clk);
        bus.init = 1'b0;
        wait_done();
        start(kb);
        wait_done();

        start({$urandom, $urandom, $urandom, $urandom});
        repeat (29) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        q.delete();
        check_cleared();
        start({$urandom, $urandom, $urandom, $urandom});
        wait_done();

        for (int j = 0; j < 3; j++) begin
            start({$urandom, $urandom, $urandom, $urandom});
            wait_done();
        end

        ka = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        bus.key  = ka;
        bus.init = 1'b1;
        @(posedge clk);
        #1;
        it.rk = expand(ka);
        it.e0 = cyc;
        q.push_back(it);
        it.e0 = cyc + 51;
        q.push_back(it);
        repeat (51) @(posedge clk);
        @(negedge clk);
        bus.init = 1'b0;
        chk("b2b_done_pulse", 128'(bus.key_exp_done), 128'd0);
        wait_done();

        repeat (3) @(negedge clk);
        chk("queue_drained", 128'(q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
